// File: rtl/ifft_butterfly_pipe.sv
// Radix-2 DIT butterfly: y0 = a + b*w, y1 = a - b*w over a 4-stage valid/ready pipeline
// fed by a registered twiddle ROM pair. Define IFFT_BFLY_SAT_EN for saturation and sticky out_ovf.
module ifft_butterfly_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a_re,
  input  logic [DATA_W-1:0] in_a_im,
  input  logic [DATA_W-1:0] in_b_re,
  input  logic [DATA_W-1:0] in_b_im,
  input  logic [ADDR_W-1:0] in_tw_idx,
  output logic [ADDR_W-1:0] tw_addr,
  input  logic [DATA_W-1:0] tw_re,
  input  logic [DATA_W-1:0] tw_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_y0_re,
  output logic [DATA_W-1:0] out_y0_im,
  output logic [DATA_W-1:0] out_y1_re,
  output logic [DATA_W-1:0] out_y1_im,
  output logic              out_ovf
);

  localparam int PW  = 2 * DATA_W;
  localparam int SW  = PW + 1;
  localparam int PRW = DATA_W + 1;
  localparam int YW  = DATA_W + 2;
  localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};
  localparam logic [PRW-1:0]    ZERO_P = {PRW{1'b0}};

  logic                     en_s;
  logic                     v1_r, v2_r, v3_r, en_q_r;
  logic signed [DATA_W-1:0] a1_re_r, a1_im_r, b1_re_r, b1_im_r;
  logic signed [DATA_W-1:0] a2_re_r, a2_im_r, b2_re_r, b2_im_r;
  logic signed [DATA_W-1:0] a3_re_r, a3_im_r;
  logic signed [PRW-1:0]    p_re_r, p_im_r, p_re_s, p_im_s;
  logic signed [DATA_W-1:0] tw_hold_re_r, tw_hold_im_r, w_re_s, w_im_s;
  logic signed [PW-1:0]     m_rr_s, m_ii_s, m_ri_s, m_ir_s;
  logic signed [SW-1:0]     sum_re_s, sum_im_s;
  logic [DATA_W-1:0]        y0_re_s, y0_im_s, y1_re_s, y1_im_s;

  // Global stall: every stage advances together, so bubbles never collapse.
  assign en_s     = !out_valid || out_ready;
  assign in_ready = en_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_r    <= 1'b0;
      v2_r    <= 1'b0;
      tw_addr <= {ADDR_W{1'b0}};
      a1_re_r <= ZERO_D; a1_im_r <= ZERO_D; b1_re_r <= ZERO_D; b1_im_r <= ZERO_D;
      a2_re_r <= ZERO_D; a2_im_r <= ZERO_D; b2_re_r <= ZERO_D; b2_im_r <= ZERO_D;
    end else if (en_s) begin
      v1_r <= in_valid;
      if (in_valid) begin
        a1_re_r <= in_a_re; a1_im_r <= in_a_im;
        b1_re_r <= in_b_re; b1_im_r <= in_b_im;
        tw_addr <= in_tw_idx;
      end
      v2_r    <= v1_r;
      a2_re_r <= a1_re_r; a2_im_r <= a1_im_r;
      b2_re_r <= b1_re_r; b2_im_r <= b1_im_r;
    end
  end

  // Once a stall begins tw_addr may already name the S1 item, so S2 keeps a copy of its own twiddle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q_r       <= 1'b0;
      tw_hold_re_r <= ZERO_D;
      tw_hold_im_r <= ZERO_D;
    end else begin
      en_q_r <= en_s;
      if (en_q_r) begin
        tw_hold_re_r <= tw_re;
        tw_hold_im_r <= tw_im;
      end
    end
  end

  assign w_re_s = en_q_r ? tw_re : tw_hold_re_r;
  assign w_im_s = en_q_r ? tw_im : tw_hold_im_r;

  always_comb begin
    m_rr_s   = PW'(b2_re_r) * PW'(w_re_s);
    m_ii_s   = PW'(b2_im_r) * PW'(w_im_s);
    m_ri_s   = PW'(b2_re_r) * PW'(w_im_s);
    m_ir_s   = PW'(b2_im_r) * PW'(w_re_s);
    sum_re_s = SW'(m_rr_s) - SW'(m_ii_s);
    sum_im_s = SW'(m_ri_s) + SW'(m_ir_s);
    p_re_s   = PRW'(sum_re_s >>> FRAC_W);
    p_im_s   = PRW'(sum_im_s >>> FRAC_W);
  end

`ifdef IFFT_BFLY_SAT_EN
  logic signed [YW-1:0] y0_re_f, y0_im_f, y1_re_f, y1_im_f;
  logic                 ovf_s;

  function automatic logic ovf_y(input logic signed [YW-1:0] x);
    ovf_y = (x[YW-1:DATA_W-1] != {(YW-DATA_W+1){x[YW-1]}});
  endfunction

  function automatic logic [DATA_W-1:0] sat_y(input logic signed [YW-1:0] x);
    if (!ovf_y(x)) begin
      sat_y = x[DATA_W-1:0];
    end else if (x[YW-1]) begin
      sat_y = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat_y = {1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction

  always_comb begin
    y0_re_f = YW'(a3_re_r) + YW'(p_re_r);
    y0_im_f = YW'(a3_im_r) + YW'(p_im_r);
    y1_re_f = YW'(a3_re_r) - YW'(p_re_r);
    y1_im_f = YW'(a3_im_r) - YW'(p_im_r);
    y0_re_s = sat_y(y0_re_f);
    y0_im_s = sat_y(y0_im_f);
    y1_re_s = sat_y(y1_re_f);
    y1_im_s = sat_y(y1_im_f);
    ovf_s   = ovf_y(y0_re_f) | ovf_y(y0_im_f) | ovf_y(y1_re_f) | ovf_y(y1_im_f);
  end

  // Sticky until reset; only a real transfer into S4 may raise it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_ovf <= 1'b0;
    end else if (en_s && v3_r && ovf_s) begin
      out_ovf <= 1'b1;
    end
  end
`else
  always_comb begin
    y0_re_s = DATA_W'(YW'(a3_re_r) + YW'(p_re_r));
    y0_im_s = DATA_W'(YW'(a3_im_r) + YW'(p_im_r));
    y1_re_s = DATA_W'(YW'(a3_re_r) - YW'(p_re_r));
    y1_im_s = DATA_W'(YW'(a3_im_r) - YW'(p_im_r));
  end

  assign out_ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v3_r      <= 1'b0;
      a3_re_r   <= ZERO_D; a3_im_r <= ZERO_D;
      p_re_r    <= ZERO_P; p_im_r  <= ZERO_P;
      out_valid <= 1'b0;
      out_y0_re <= ZERO_D; out_y0_im <= ZERO_D;
      out_y1_re <= ZERO_D; out_y1_im <= ZERO_D;
    end else if (en_s) begin
      v3_r      <= v2_r;
      a3_re_r   <= a2_re_r; a3_im_r <= a2_im_r;
      p_re_r    <= p_re_s;  p_im_r  <= p_im_s;
      out_valid <= v3_r;
      out_y0_re <= y0_re_s; out_y0_im <= y0_im_s;
      out_y1_re <= y1_re_s; out_y1_im <= y1_im_s;
    end
  end

endmodule

// File: tb/tb_ifft_butterfly_pipe.sv
// Scoreboard bench for ifft_butterfly_pipe: directed vectors, a registered twiddle ROM model,
// and a monitor that pops expected results on every output transfer.
module tb_ifft_butterfly_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [15:0] in_a_re, in_a_im, in_b_re, in_b_im, tw_re, tw_im;
  logic [15:0] out_y0_re, out_y0_im, out_y1_re, out_y1_im;
  logic [4:0]  in_tw_idx, tw_addr;

  logic [15:0] rom_re [32];
  logic [15:0] rom_im [32];

  typedef struct {
    logic [63:0] y;
    logic        sat;
    logic        lat;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int chk_cnt = 0;
  int pass_cnt = 0;

`ifdef IFFT_BFLY_SAT_EN
  localparam logic [15:0] T4_Y0 = 16'h7FFF;
  localparam logic        T4_OVF = 1'b1;
`else
  localparam logic [15:0] T4_Y0 = 16'h8100;
  localparam logic        T4_OVF = 1'b0;
`endif

  ifft_butterfly_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a_re(in_a_re), .in_a_im(in_a_im), .in_b_re(in_b_re), .in_b_im(in_b_im),
    .in_tw_idx(in_tw_idx), .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y0_re(out_y0_re), .out_y0_im(out_y0_im), .out_y1_re(out_y1_re), .out_y1_im(out_y1_im),
    .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read twiddle ROM pair.
  always @(posedge clk) begin
    tw_re <= rom_re[tw_addr];
    tw_im <= rom_im[tw_addr];
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      rom_re[i] = 16'(256 - i * 17);
      rom_im[i] = 16'(i * 19 - 64);
    end
    rom_re[5]  = 16'h0000; rom_im[5]  = 16'h0100;
    rom_re[10] = 16'h0100; rom_im[10] = 16'h0000;
    rom_re[11] = 16'h00B5; rom_im[11] = 16'h0000;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference butterfly: floor-shifted product kept at 17 bits, then wrap or clamp.
  function automatic void model(input logic [15:0] are, aim, bre, bim, input logic [4:0] idx,
                                output logic [63:0] y, output logic s);
    longint wr, wi, pr, pi;
    longint r[4];
    wr = longint'($signed(rom_re[idx]));
    wi = longint'($signed(rom_im[idx]));
    pr = (longint'($signed(bre)) * wr - longint'($signed(bim)) * wi) >>> 8;
    pi = (longint'($signed(bre)) * wi + longint'($signed(bim)) * wr) >>> 8;
    pr = (pr <<< 47) >>> 47;
    pi = (pi <<< 47) >>> 47;
    r[0] = longint'($signed(are)) + pr;
    r[1] = longint'($signed(aim)) + pi;
    r[2] = longint'($signed(are)) - pr;
    r[3] = longint'($signed(aim)) - pi;
    s = 1'b0;
`ifdef IFFT_BFLY_SAT_EN
    for (int k = 0; k < 4; k++) begin
      if (r[k] > 32767) begin r[k] = 32767; s = 1'b1; end
      else if (r[k] < -32768) begin r[k] = -32768; s = 1'b1; end
    end
`endif
    y = {16'(r[0]), 16'(r[1]), 16'(r[2]), 16'(r[3])};
  endfunction

  task automatic send(input logic [15:0] are, aim, bre, bim, input logic [4:0] idx,
                      input logic [63:0] ey, input logic es, input logic lat, input logic must_ready);
    int waited;
    in_valid = 1'b1;
    in_a_re = are; in_a_im = aim; in_b_re = bre; in_b_im = bim; in_tw_idx = idx;
    waited = 0;
    @(negedge clk);
    if (must_ready) chk("in_ready_open", 64'(in_ready), 64'd1);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk_cnt++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 20 cycles");
    end else begin
      exp_q.push_back('{ey, es, lat, cyc});
    end
    @(posedge clk); #1;
    chk("tw_addr", 64'(tw_addr), 64'(idx));
  endtask

  task automatic send_model(input logic [15:0] are, aim, bre, bim, input logic [4:0] idx,
                            input logic lat);
    logic [63:0] y;
    logic s;
    model(are, aim, bre, bim, idx, y, s);
    send(are, aim, bre, bim, idx, y, s, lat, 1'b1);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: compare every output transfer with the head of the scoreboard.
  initial begin
    exp_t it;
    logic sticky;
    sticky = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sticky = 1'b0;
      end else if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_out: got %h%h%h%h with empty scoreboard, required no output",
                   out_y0_re, out_y0_im, out_y1_re, out_y1_im);
        end else begin
          it = exp_q.pop_front();
          sticky = sticky | it.sat;
          chk("result", {out_y0_re, out_y0_im, out_y1_re, out_y1_im}, it.y);
          chk("ovf", 64'(out_ovf), 64'(sticky));
          if (it.lat) chk("latency", 64'(cyc - it.acc), 64'd4);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p_y;
    logic        p_s;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a_re = 16'h0000; in_a_im = 16'h0000; in_b_re = 16'h0000; in_b_im = 16'h0000;
    in_tw_idx = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_tw_addr", 64'(tw_addr), 64'd0);
    chk("rst_ovf", 64'(out_ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // Basic multiply, w = j
    send(16'h0100, 16'h0000, 16'h0100, 16'h0080, 5'd5,
         {16'h0080, 16'h0100, 16'h0180, 16'hFF00}, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    drain();

    // Streaming, idx 0..7
    for (int i = 0; i < 8; i++)
      send_model(16'(i * 64 + 16), 16'(-i * 33), 16'(128 - i * 21), 16'(i * 49 + 3), 5'(i), 1'b1);
    in_valid = 1'b0;
    drain();

    // Back-pressure while Y (idx 5) sits in S2 and Z (idx 9) in S1
    model(16'h0100, 16'h0020, 16'h0040, 16'h0010, 5'd1, p_y, p_s);
    send(16'h0100, 16'h0020, 16'h0040, 16'h0010, 5'd1, p_y, p_s, 1'b0, 1'b1);
    send_model(16'h0010, 16'h0020, 16'h0100, 16'h0080, 5'd3, 1'b0);
    send_model(16'h0030, 16'hFFE0, 16'h0100, 16'h0080, 5'd5, 1'b0);
    send_model(16'hFF80, 16'h0040, 16'h0100, 16'h0080, 5'd9, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_hold", {out_y0_re, out_y0_im, out_y1_re, out_y1_im}, p_y);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();

    // Saturation / wrap
    send(16'h7F00, 16'h0000, 16'h0200, 16'h0000, 5'd10,
         {T4_Y0, 16'h0000, 16'h7D00, 16'h0000}, T4_OVF, 1'b1, 1'b1);
    in_valid = 1'b0;
    drain();

    // Negative truncation toward -inf
    send(16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 5'd11,
         {16'hFFFF, 16'h0000, 16'h0001, 16'h0000}, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    drain();

    // Reset with three items in flight
    send_model(16'h0011, 16'h0022, 16'h0033, 16'h0044, 5'd2, 1'b1);
    send_model(16'h0055, 16'h0066, 16'h0077, 16'h0088, 5'd4, 1'b1);
    send_model(16'h0099, 16'h00AA, 16'h00BB, 16'h00CC, 5'd6, 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_tw_addr", 64'(tw_addr), 64'd0);
    chk("rst2_ovf", 64'(out_ovf), 64'd0);
    chk("rst2_in_ready", 64'(in_ready), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    send(16'h0100, 16'h0000, 16'h0100, 16'h0080, 5'd5,
         {16'h0080, 16'h0100, 16'h0180, 16'hFF00}, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ifft_butterfly_pipe.md
Name: ifft_butterfly_pipe

Overview:
- Radix-2 DIT butterfly datapath for the IFFT engine; sits directly downstream of the twiddle ROM pair (real/imag, 5-bit address, 16-bit Q8 data, 1-cycle registered read).
- Accepts operand pairs with a twiddle index, drives the ROM address, and computes y0 = a + b·w and y1 = a − b·w.
- Valid/ready on both sides; pipeline stalls on back-pressure without losing the ROM data.

Parameters:
- DATA_W, 16, signed sample width, two's complement.
- FRAC_W, 8, fractional bits of the Q format; twiddle 1.0 = 0x0100.
- ADDR_W, 5, twiddle ROM address width.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, operand pair valid.
- in_ready, output, 1, block can accept; combinational, equals the pipeline enable.
- in_a_re / in_a_im, input, DATA_W each, operand a.
- in_b_re / in_b_im, input, DATA_W each, operand b.
- in_tw_idx, input, ADDR_W, twiddle index for this pair.
- tw_addr, output, ADDR_W, registered address to both twiddle ROMs.
- tw_re / tw_im, input, DATA_W each, ROM outputs, valid one cycle after tw_addr.
- out_valid, output, 1, results valid.
- out_ready, input, 1, downstream accepts.
- out_y0_re / out_y0_im / out_y1_re / out_y1_im, output, DATA_W each, results.
- out_ovf, output, 1, sticky overflow flag (see Optional Feature).

Behaviour:
Pipeline control
- en = !out_valid | out_ready; in_ready = en.
- All pipeline registers, valid bits and tw_addr update only when en = 1.
- Global stall: bubbles do not collapse.

Stage S1 (edge where in_valid & en)
- Register a, b, and v1 = 1.
- Set tw_addr <= in_tw_idx.
- If en = 1 and in_valid = 0, v1 <= 0 and tw_addr holds its value.

Stage S2
- a, b and v1 move to S2 regs (v2).
- The ROM data for this item is live in the cycle the item sits in S2.

Twiddle skid
- en_q = en registered every cycle, regardless of en.
- tw_hold_re/im load from live tw_re/im on every cycle where en_q = 1.
- The multiplier uses the live ROM data when en_q = 1, otherwise tw_hold.
- This guarantees the S2 item keeps its own twiddle while tw_addr already points at the S1 item.

Stage S3 (multiply)
- p_re = (b_re·w_re − b_im·w_im) >>> FRAC_W.
- p_im = (b_re·w_im + b_im·w_re) >>> FRAC_W.
- Products are full 2·DATA_W; the sum is kept at 2·DATA_W+1 bits; the shift is arithmetic, truncating toward −∞; the result is kept at DATA_W+1 bits. Sets v3.

Stage S4 (output)
- y0 = a + p and y1 = a − p, computed at DATA_W+2 bits, then reduced to DATA_W (see Optional Feature).
- Sets out_valid = v3.

Latency and throughput
- Accept at edge E1 gives out_valid high after edge E4: 4 cycles.
- Throughput is 1 pair per cycle when out_ready stays high.
- out_valid & !out_ready holds all outputs and the entire pipeline stable.
- An item accepted during the same cycle in which an output transfers proceeds normally.

Reset (rst_n = 0 at a clock edge)
- All valid bits, out_valid, tw_addr, en_q, tw_hold, data registers and out_ovf are cleared to 0.
- Reset mid-operation discards all in-flight items.
- in_ready is 1 in the first cycle after reset.

Optional Feature:
- Macro IFFT_BFLY_SAT_EN, defined:
  - y0/y1 saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1], i.e. 0x8000..0x7FFF.
  - out_ovf sets sticky whenever any output component saturates on a transfer into S4.
  - out_ovf clears only on reset.
- Macro undefined:
  - Results wrap (low DATA_W bits kept).
  - out_ovf is tied to 0.

Test Plan:
1. Basic multiply. Bench ROM model returns w = (0x0000, 0x0100) at idx 5; send a = (0x0100, 0), b = (0x0100, 0x0080), idx 5, out_ready = 1 -> after 4 cycles y0 = (0x0080, 0x0100), y1 = (0x0180, 0xFF00); tw_addr = 5 one cycle after accept.
2. Streaming. 8 back-to-back pairs with idx 0..7, out_ready = 1 -> 8 consecutive out_valid cycles starting 4 cycles after the first accept, results matching the golden model in order, in_ready constantly 1.
3. Back-pressure skid. Stream idx 3, 5, 9 with distinct twiddles; drop out_ready for 3 cycles while an item is in S2 -> in_ready = 0 during the stall, outputs held, each result uses its own twiddle, no loss or duplication after release.
4. Saturation. w = (0x0100, 0), a = (0x7F00, 0), b = (0x0200, 0):
   - with IFFT_BFLY_SAT_EN: y0_re = 0x7FFF, y1_re = 0x7D00, out_ovf = 1.
   - without it: y0_re = 0x8100, out_ovf = 0.
5. Negative truncation. w = (0x00B5, 0), b = (0xFFFF, 0), a = 0 -> p_re = −1 (floor of −181/256), so y0_re = 0xFFFF and y1_re = 0x0001.
6. Reset mid-stream. Assert rst_n = 0 for 1 cycle with 3 items in flight -> the next cycle out_valid = 0, tw_addr = 0, out_ovf = 0, in_ready = 1, and no stale result ever appears.
